// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential IEEE-754 single-precision divider, result = a / b.
// Mantissas are divided with radix-2 restoring division (one quotient bit per
// clock), then normalised and rounded to nearest-even. Fixed latency: a start
// accepted in cycle T yields done in cycle T+29 for every operand pair.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   start        request, sampled only while idle
//   a, b         dividend / divisor (IEEE-754 single)
//   busy         high from the cycle after an accepted start through the done cycle
//   done         one-cycle pulse, result and flags valid from this cycle
//   result       quotient, held until the next completed operation
//   exception    a or b has an all-ones exponent (Inf/NaN)
//   overflow     rounded biased exponent >= 255
//   underflow    rounded biased exponent <= 0
//   div_by_zero  b is zero while a is nonzero and finite
module fp_divider_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   exception,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   div_by_zero
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 1;          // mantissa incl. hidden bit
  localparam int QW   = MAN_W + 3;          // quotient bits: 1 int + 23 + guard + extra
  localparam int XW   = EXP_W + 2;          // signed working exponent
  localparam int CW   = $clog2(QW);
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_ROUND, S_DONE} state_t;

  typedef struct packed {
    logic exc;
    logic ovf;
    logic unf;
    logic dbz;
  } flags_t;

  state_t            state, state_nx;
  logic [W-1:0]      a_op, b_op;
  logic              sign_q, exc_q, a_zero_q, b_zero_q;
  logic [XW-1:0]     exp_diff_q;
  logic [MW:0]       rem_q;
  logic [MW-1:0]     mb_q;
  logic [QW-1:0]     q_q;
  logic [CW-1:0]     cnt_q;
  flags_t            flags_q;

  logic              accept;
  logic              q_bit;
  logic [MW:0]       rem_diff;

  // Rounding / result selection, evaluated while in ROUND.
  logic [MAN_W-1:0]  man_t;
  logic [MAN_W:0]    man_inc;
  logic              guard, sticky, round_up;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]      res_nx;
  flags_t            flags_nx;

  assign accept = start && (state == S_IDLE);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  assign exception   = flags_q.exc;
  assign overflow    = flags_q.ovf;
  assign underflow   = flags_q.unf;
  assign div_by_zero = flags_q.dbz;

  // One restoring step: the remainder is kept pre-shifted, so the next
  // dividend bit (always zero after the mantissa is consumed) is implicit.
  assign q_bit    = (rem_q >= {1'b0, mb_q});
  assign rem_diff = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_DIV;
      S_DIV:   if (cnt_q == CW'(QW-1)) state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    man_t    = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    exp_r    = exp_diff_q;
    // Quotient lies in [2^24, 2^26): the top bit picks the normalisation shift.
    if (q_q[QW-1]) begin
      man_t  = q_q[QW-2:2];
      guard  = q_q[1];
      sticky = q_q[0] | (rem_q != '0);
    end else begin
      man_t  = q_q[QW-3:1];
      guard  = q_q[0];
      sticky = (rem_q != '0);
      exp_r  = exp_diff_q - XW'(1);
    end
    round_up = guard & (sticky | man_t[0]);
    man_inc  = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    if (man_inc[MAN_W]) exp_r = exp_r + XW'(1);

    res_nx   = '0;
    flags_nx = '0;
    if (exc_q) begin
      flags_nx.exc = 1'b1;
    end else if (a_zero_q) begin
      res_nx = '0;                       // zero dividend gives +0, including 0/0
    end else if (b_zero_q) begin
      res_nx       = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_nx.dbz = 1'b1;
    end else if (int'(exp_r) >= EMAX) begin
      res_nx       = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_nx.ovf = 1'b1;
    end else if (int'(exp_r) <= 0) begin
      res_nx       = {sign_q, {(W-1){1'b0}}};
      flags_nx.unf = 1'b1;
    end else begin
      res_nx = {sign_q, exp_r[EXP_W-1:0], man_inc[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_op       <= '0;
      b_op       <= '0;
      sign_q     <= 1'b0;
      exc_q      <= 1'b0;
      a_zero_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      exp_diff_q <= '0;
      rem_q      <= '0;
      mb_q       <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      flags_q    <= '0;
      result     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_op    <= a;
        b_op    <= b;
        flags_q <= '0;
      end
      case (state)
        S_LOAD: begin
          sign_q     <= a_op[W-1] ^ b_op[W-1];
          exc_q      <= (&a_op[W-2:MAN_W]) | (&b_op[W-2:MAN_W]);
          // Exponent 0 (zero or denormal) is flushed to zero.
          a_zero_q   <= (a_op[W-2:MAN_W] == '0);
          b_zero_q   <= (b_op[W-2:MAN_W] == '0);
          exp_diff_q <= XW'(a_op[W-2:MAN_W]) - XW'(b_op[W-2:MAN_W]) + XW'(BIAS);
          rem_q      <= {2'b01, a_op[MAN_W-1:0]};
          mb_q       <= {1'b1, b_op[MAN_W-1:0]};
          q_q        <= '0;
          cnt_q      <= '0;
        end
        S_DIV: begin
          q_q   <= {q_q[QW-2:0], q_bit};
          rem_q <= rem_diff << 1;
          cnt_q <= cnt_q + CW'(1);
        end
        S_ROUND: begin
          result  <= res_nx;
          flags_q <= flags_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Bench for fp_divider_seq: directed corner cases plus randomized operands.
// Expected results are queued at issue time and checked by an independent
// monitor whenever done is seen (result, flags and latency).
module tb_fp_divider_seq;

  logic        clk, rst, start;
  logic [31:0] a, b;
  logic        busy, done, exception, overflow, underflow, div_by_zero;
  logic [31:0] result;

  fp_divider_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .exception(exception), .overflow(overflow),
    .underflow(underflow), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {exception, overflow, underflow, div_by_zero}
    int          t;
  } exp_t;

  exp_t q[$];
  int   cmps = 0;
  int   errs = 0;
  int   cyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    cmps++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: quotient from plain integer division of the mantissas, then
  // normalisation, round-to-nearest-even and the result priority list.
  function automatic void model(input logic [31:0] fa, input logic [31:0] fb,
                                output logic [31:0] r, output logic [3:0] f);
    int      ea, eb, e;
    longint  ma, mb, num, qt, rm, man;
    bit      g, st, s;
    ea  = int'(fa[30:23]);
    eb  = int'(fb[30:23]);
    ma  = longint'({1'b1, fa[22:0]});
    mb  = longint'({1'b1, fb[22:0]});
    num = ma * (64'd1 << 25);
    qt  = num / mb;
    rm  = num % mb;
    if (qt >= (64'd1 << 25)) begin
      man = (qt / 4) % (64'd1 << 23);
      g   = qt[1];
      st  = qt[0] || (rm != 0);
      e   = ea - eb + 127;
    end else begin
      man = (qt / 2) % (64'd1 << 23);
      g   = qt[0];
      st  = (rm != 0);
      e   = ea - eb + 126;
    end
    if (g && (st || man[0])) man = man + 1;
    if (man == (64'd1 << 23)) begin man = 0; e = e + 1; end
    s = fa[31] ^ fb[31];
    r = 32'h0;
    f = 4'b0000;
    if (ea == 255 || eb == 255) f = 4'b1000;
    else if (ea == 0)           r = 32'h0;
    else if (eb == 0)           begin r = {s, 8'hFF, 23'd0}; f = 4'b0001; end
    else if (e >= 255)          begin r = {s, 8'hFF, 23'd0}; f = 4'b0100; end
    else if (e <= 0)            begin r = {s, 31'd0};        f = 4'b0010; end
    else                        r = {s, 8'(e), man[22:0]};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Drive one request for one cycle; when push is set the expectation is queued.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit push,
                       input bit use_model, input logic [31:0] er, input logic [3:0] ef);
    exp_t        e;
    logic [31:0] mr;
    logic [3:0]  mf;
    wait_idle();
    start = 1'b1; a = ia; b = ib;
    if (use_model) begin model(ia, ib, mr, mf); e.res = mr; e.flg = mf; end
    else begin e.res = er; e.flg = ef; end
    e.t = cyc;
    if (push) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    check("busy_after_start", 32'(busy), 32'd1);
    check("flags_cleared", {28'd0, exception, overflow, underflow, div_by_zero}, 32'd0);
  endtask

  // Monitor: pops the oldest expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("flags", {28'd0, exception, overflow, underflow, div_by_zero}, {28'd0, e.flg});
        check("latency", 32'(cyc - e.t), 32'd29);
      end
    end
  end

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    int sel = $urandom_range(0, 15);
    case (sel)
      0:       ex = 8'd0;
      1:       ex = 8'd255;
      2:       ex = 8'($urandom_range(240, 254));
      3:       ex = 8'($urandom_range(1, 12));
      default: ex = 8'($urandom_range(64, 190));
    endcase
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, exception, overflow, underflow, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations.
    issue(32'h40C00000, 32'h40000000, 1, 0, 32'h40400000, 4'b0000);
    // start pulsed mid-operation must be ignored.
    repeat (4) @(negedge clk);
    start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    // start during the done cycle must be ignored too.
    n = 0;
    while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    check("done_seen", 32'(done), 32'd1);
    start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);

    issue(32'h3F800000, 32'h40400000, 1, 0, 32'h3EAAAAAB, 4'b0000);
    issue(32'hC1200000, 32'h00000000, 1, 0, 32'hFF800000, 4'b0001);
    issue(32'h00000000, 32'h3F800000, 1, 0, 32'h00000000, 4'b0000);
    issue(32'h00000000, 32'h00000000, 1, 0, 32'h00000000, 4'b0000);
    issue(32'h7F000000, 32'h00800000, 1, 0, 32'h7F800000, 4'b0100);
    issue(32'h00800000, 32'h40000000, 1, 0, 32'h00000000, 4'b0010);
    issue(32'h7F800000, 32'h3F800000, 1, 0, 32'h00000000, 4'b1000);
    issue(32'hBF800000, 32'h3F800000, 1, 0, 32'hBF800000, 4'b0000);

    // Abort by reset during DIV iteration 10: no done for this request.
    issue(32'h40C00000, 32'h40400000, 0, 0, 32'h0, 4'b0000);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("busy_after_abort", 32'(busy), 32'd0);
    repeat (35) @(negedge clk);
    issue(32'h41200000, 32'h40A00000, 1, 0, 32'h40000000, 4'b0000);

    // Randomized operands against the reference model.
    for (int i = 0; i < 150; i++) issue(rand_fp(), rand_fp(), 1, 1, 32'h0, 4'b0000);

    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("queue_drained", 32'(q.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
